// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline-register types, exception codes and bubble beat
package pipe_pkg;

  localparam int DATA_W = 32;
  localparam int NLANE  = 4;
  localparam int EXC_W  = 5;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  // Interrupt is moved off code 0 because 0 is reserved for "no exception".
  localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_W-1:0] EXC_INT  = 5'd31;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
  localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

  typedef enum logic [1:0] {
    LVL_EMPTY = 2'd0,
    LVL_ONE   = 2'd1,
    LVL_FULL  = 2'd2
  } level_e;

  typedef struct packed {
    logic [DATA_W-1:0]       ir;
    logic [DATA_W-1:0]       pc;
    logic [NLANE*DATA_W-1:0] lanes;
    logic [DATA_W-1:0]       res;
    logic                    bd;
    logic                    br_true;
    logic [EXC_W-1:0]        exc;
  } beat_t;

  localparam beat_t BUBBLE = '{ir: '0, pc: RESET_PC, lanes: '0, res: '0,
                               bd: 1'b0, br_true: 1'b0, exc: EXC_NONE};

  function automatic int sel_w(input int nsrc);
    return (nsrc > 1) ? $clog2(nsrc) : 1;
  endfunction

endpackage

// File: rtl/stage_skid_pipereg_beat_pack.sv
// rtl/stage_skid_pipereg_beat_pack.sv - result select, exception merge and beat packing
module beat_pack #(
  parameter int DATA_W = 32,
  parameter int NLANE  = 4,
  parameter int NSRC   = 2,
  parameter int EXC_W  = 5,
  parameter int SEL_W  = 1,
  localparam int BEAT_W = (3 + NLANE) * DATA_W + 2 + EXC_W
) (
  input  logic [DATA_W-1:0]       ir,
  input  logic [DATA_W-1:0]       pc,
  input  logic [NLANE*DATA_W-1:0] lanes,
  input  logic [NSRC*DATA_W-1:0]  res,
  input  logic [SEL_W-1:0]        res_sel,
  input  logic                    bd,
  input  logic                    br_true,
  input  logic [EXC_W-1:0]        exc_now,
  input  logic [EXC_W-1:0]        exc_pre,
  output logic [BEAT_W-1:0]       beat
);
  import pipe_pkg::*;

  logic [DATA_W-1:0] res_mux;
  logic [EXC_W-1:0]  exc_mux;

  // Out-of-range selects fall back to source 0.
  always_comb begin
    res_mux = res[DATA_W-1:0];
    for (int i = 1; i < NSRC; i++) begin
      if (int'(res_sel) == i) res_mux = res[i*DATA_W +: DATA_W];
    end
  end

  assign exc_mux = (exc_now != EXC_W'(EXC_NONE)) ? exc_now : exc_pre;

  assign beat = {ir, pc, lanes, res_mux, bd, br_true, exc_mux};

endmodule

// File: rtl/stage_skid_pipereg.sv
// rtl/stage_skid_pipereg.sv - valid/ready pipeline register with 2-entry skid and flush
module stage_skid_pipereg #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int NLANE  = pipe_pkg::NLANE,
  parameter int NSRC   = 2,
  parameter int EXC_W  = pipe_pkg::EXC_W,
  parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(pipe_pkg::RESET_PC),
  localparam int SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_ir,
  input  logic [DATA_W-1:0]       in_pc,
  input  logic [NLANE*DATA_W-1:0] in_lanes,
  input  logic [NSRC*DATA_W-1:0]  in_res,
  input  logic [SEL_W-1:0]        in_res_sel,
  input  logic                    in_bd,
  input  logic                    in_br_true,
  input  logic [EXC_W-1:0]        exc_now,
  input  logic [EXC_W-1:0]        exc_pre,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_ir,
  output logic [DATA_W-1:0]       out_pc,
  output logic [NLANE*DATA_W-1:0] out_lanes,
  output logic [DATA_W-1:0]       out_res,
  output logic                    out_bd,
  output logic                    out_br_true,
  output logic [EXC_W-1:0]        out_exc,
  output logic [1:0]              level
);
  import pipe_pkg::*;

  typedef struct packed {
    logic [DATA_W-1:0]       ir;
    logic [DATA_W-1:0]       pc;
    logic [NLANE*DATA_W-1:0] lanes;
    logic [DATA_W-1:0]       res;
    logic                    bd;
    logic                    br_true;
    logic [EXC_W-1:0]        exc;
  } stage_beat_t;

  localparam stage_beat_t BUBBLE_BEAT = '{ir: '0, pc: RESET_PC, lanes: '0, res: '0,
                                          bd: 1'b0, br_true: 1'b0, exc: '0};

  logic [$bits(stage_beat_t)-1:0] in_beat_vec;
  stage_beat_t in_beat, head, skid;
  level_e      occ, occ_n;
  logic        accept, pop;

  beat_pack #(
    .DATA_W(DATA_W), .NLANE(NLANE), .NSRC(NSRC), .EXC_W(EXC_W), .SEL_W(SEL_W)
  ) u_beat_pack (
    .ir(in_ir), .pc(in_pc), .lanes(in_lanes), .res(in_res), .res_sel(in_res_sel),
    .bd(in_bd), .br_true(in_br_true), .exc_now(exc_now), .exc_pre(exc_pre),
    .beat(in_beat_vec)
  );

  assign in_beat = in_beat_vec;
  assign accept  = in_valid & in_ready;
  assign pop     = out_valid & out_ready;

  always_comb begin
    occ_n = occ;
    case (occ)
      LVL_EMPTY: if (accept) occ_n = LVL_ONE;
      LVL_ONE: begin
        if (pop && !accept)      occ_n = LVL_EMPTY;
        else if (accept && !pop) occ_n = LVL_FULL;
      end
      LVL_FULL:  if (pop) occ_n = LVL_ONE;
      default:   occ_n = LVL_EMPTY;
    endcase
    if (flush) occ_n = LVL_EMPTY;
  end

  // in_ready and out_valid are registered from the next occupancy so no
  // combinational path crosses the register in either direction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head      <= BUBBLE_BEAT;
      skid      <= BUBBLE_BEAT;
      occ       <= LVL_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      occ       <= occ_n;
      in_ready  <= (occ_n != LVL_FULL);
      out_valid <= (occ_n != LVL_EMPTY);
      if (flush) begin
        head <= BUBBLE_BEAT;
        skid <= BUBBLE_BEAT;
      end else begin
        case (occ)
          LVL_EMPTY: if (accept) head <= in_beat;
          LVL_ONE: begin
            if (accept && pop) head <= in_beat;
            else if (accept)   skid <= in_beat;
            else if (pop)      head <= BUBBLE_BEAT;
          end
          LVL_FULL: begin
            if (pop) begin
              head <= skid;
              skid <= BUBBLE_BEAT;
            end
          end
          default: begin
            head <= BUBBLE_BEAT;
            skid <= BUBBLE_BEAT;
          end
        endcase
      end
    end
  end

  assign out_ir      = head.ir;
  assign out_pc      = head.pc;
  assign out_lanes   = head.lanes;
  assign out_res     = head.res;
  assign out_bd      = head.bd;
  assign out_br_true = head.br_true;
  assign out_exc     = head.exc;
  assign level       = occ;

endmodule

// File: tb/tb_stage_skid_pipereg.sv
// tb/tb_stage_skid_pipereg.sv - scoreboard bench for stage_skid_pipereg
module tb_stage_skid_pipereg;

  localparam int NS = 3;

  logic         clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]  in_ir, in_pc, out_ir, out_pc, out_res;
  logic [127:0] in_lanes, out_lanes;
  logic [95:0]  in_res;
  logic [1:0]   in_res_sel, level;
  logic         in_bd, in_br_true, out_bd, out_br_true;
  logic [4:0]   exc_now, exc_pre, out_exc;

  typedef struct {
    logic [31:0]  ir;
    logic [31:0]  pc;
    logic [127:0] lanes;
    logic [31:0]  res;
    logic         bd;
    logic         br;
    logic [4:0]   exc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   c0, c1;

  stage_skid_pipereg #(.NSRC(NS)) dut (
    .clk(clk), .reset(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ir(in_ir), .in_pc(in_pc), .in_lanes(in_lanes), .in_res(in_res),
    .in_res_sel(in_res_sel), .in_bd(in_bd), .in_br_true(in_br_true),
    .exc_now(exc_now), .exc_pre(exc_pre),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ir(out_ir), .out_pc(out_pc), .out_lanes(out_lanes), .out_res(out_res),
    .out_bd(out_bd), .out_br_true(out_br_true), .out_exc(out_exc),
    .level(level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model();
    exp_t e;
    int   s;
    s = int'(in_res_sel);
    if (s >= NS) s = 0;
    e.ir    = in_ir;
    e.pc    = in_pc;
    e.lanes = in_lanes;
    e.res   = in_res[s*32 +: 32];
    e.bd    = in_bd;
    e.br    = in_br_true;
    e.exc   = (exc_now != 5'd0) ? exc_now : exc_pre;
    return e;
  endfunction

  // Occupancy model plus scoreboard; runs away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      check_eq("level", 128'(level), 128'(sb.size()));
      check_eq("in_ready", 128'(in_ready), 128'(sb.size() != 2));
      check_eq("out_valid", 128'(out_valid), 128'(sb.size() != 0));
      if (sb.size() == 0) begin
        check_eq("bubble_ir", 128'(out_ir), 128'(0));
        check_eq("bubble_pc", 128'(out_pc), 128'(32'h0000_3000));
        check_eq("bubble_exc", 128'(out_exc), 128'(0));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("pop_on_empty", 128'(out_valid), 128'(0));
        end else begin
          mon_e = sb.pop_front();
          check_eq("out_ir", 128'(out_ir), 128'(mon_e.ir));
          check_eq("out_pc", 128'(out_pc), 128'(mon_e.pc));
          check_eq("out_lanes", out_lanes, mon_e.lanes);
          check_eq("out_res", 128'(out_res), 128'(mon_e.res));
          check_eq("out_flags", 128'({out_bd, out_br_true}), 128'({mon_e.bd, mon_e.br}));
          check_eq("out_exc", 128'(out_exc), 128'(mon_e.exc));
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(model());
    end
  end

  task automatic send(input logic [31:0] ir, input logic [95:0] res, input logic [1:0] sel,
                      input logic [4:0] en, input logic [4:0] ep);
    int waited = 0;
    in_valid   = 1'b1;
    in_ir      = ir;
    in_pc      = 32'h0040_0000 + (ir << 2);
    in_lanes   = {ir ^ 32'hA5A5_0000, ir + 32'd3, ir + 32'd2, ir + 32'd1};
    in_res     = res;
    in_res_sel = sel;
    in_bd      = ir[0];
    in_br_true = ir[1];
    exc_now    = en;
    exc_pre    = ep;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) check_eq("send_timeout", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_ir(input logic [31:0] ir);
    send(ir, {32'h0, 32'h0, ir ^ 32'hFFFF}, 2'd0, 5'd0, 5'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 0; rst_n = 0; flush = 0; in_valid = 0; out_ready = 1;
    in_ir = 0; in_pc = 0; in_lanes = 0; in_res = 0; in_res_sel = 0;
    in_bd = 0; in_br_true = 0; exc_now = 0; exc_pre = 0;
    #22 rst_n = 1;

    // Reset state after three idle cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", 128'(out_valid), 128'(0));
    check_eq("rst_out_ir", 128'(out_ir), 128'(0));
    check_eq("rst_out_pc", 128'(out_pc), 128'(32'h0000_3000));
    check_eq("rst_level", 128'(level), 128'(0));
    check_eq("rst_in_ready", 128'(in_ready), 128'(1));

    // Full-throughput stream.
    @(posedge clk); #1;
    c0 = cyc;
    for (int i = 1; i <= 4; i++) send_ir(32'(i));
    c1 = cyc;
    check_eq("stream_cycles", 128'(c1 - c0), 128'(4));
    repeat (2) @(posedge clk); #1;

    // Stall into FULL, third beat held upstream, then drain.
    out_ready = 1'b0;
    send_ir(32'd10);
    send_ir(32'd11);
    fork
      send_ir(32'd12);
      begin
        @(negedge clk);
        check_eq("full_level", 128'(level), 128'(2));
        check_eq("full_in_ready", 128'(in_ready), 128'(0));
        check_eq("full_head_ir", 128'(out_ir), 128'(10));
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;

    // Exception merge and result select.
    send(32'd20, {32'h0, 32'hBEEF, 32'h1234}, 2'd1, 5'd0, 5'd4);
    @(negedge clk);
    check_eq("exc_pre_only", 128'(out_exc), 128'(4));
    check_eq("res_sel1", 128'(out_res), 128'(32'hBEEF));
    @(posedge clk); #1;
    send(32'd21, {32'h0, 32'hBEEF, 32'h1234}, 2'd3, 5'd12, 5'd4);
    @(negedge clk);
    check_eq("exc_now_wins", 128'(out_exc), 128'(12));
    check_eq("res_sel_oob", 128'(out_res), 128'(32'h1234));
    @(posedge clk); #1;

    // Flush while FULL with a beat offered.
    out_ready = 1'b0;
    send_ir(32'd30);
    send_ir(32'd31);
    flush = 1'b1; in_valid = 1'b1; in_ir = 32'd99;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_eq("flush_level", 128'(level), 128'(0));
    check_eq("flush_out_valid", 128'(out_valid), 128'(0));
    check_eq("flush_out_ir", 128'(out_ir), 128'(0));
    check_eq("flush_out_exc", 128'(out_exc), 128'(0));
    check_eq("flush_in_ready", 128'(in_ready), 128'(1));
    out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;

    // Flush in ONE with accept and pop in the same cycle.
    send_ir(32'd40);
    flush = 1'b1; in_valid = 1'b1; in_ir = 32'd41;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_eq("flush1_level", 128'(level), 128'(0));
    @(posedge clk); #1;

    // Asynchronous reset while FULL.
    out_ready = 1'b0;
    send_ir(32'd50);
    send_ir(32'd51);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", 128'(out_valid), 128'(0));
    check_eq("arst_out_ir", 128'(out_ir), 128'(0));
    check_eq("arst_out_pc", 128'(out_pc), 128'(32'h0000_3000));
    check_eq("arst_level", 128'(level), 128'(0));
    check_eq("arst_out_exc", 128'(out_exc), 128'(0));
    #3 rst_n = 1'b1;

    // Random traffic with occasional flush.
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      in_valid   = ($urandom % 2) == 0;
      in_ir      = $urandom;
      in_pc      = $urandom;
      in_lanes   = {$urandom, $urandom, $urandom, $urandom};
      in_res     = {$urandom, $urandom, $urandom};
      in_res_sel = 2'($urandom % 4);
      in_bd      = 1'($urandom);
      in_br_true = 1'($urandom);
      exc_now    = (($urandom % 2) == 0) ? 5'($urandom) : 5'd0;
      exc_pre    = 5'($urandom);
      out_ready  = ($urandom % 4) != 0;
      flush      = ($urandom % 40) == 0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("drained_level", 128'(level), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
